// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared helpers for the round-robin lock arbiter (counter width, priority mask)
package arbiter_pkg;

    function automatic int cnt_w(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

    function automatic logic [63:0] above_mask(input int idx);
        return ~64'd0 << (idx + 1);
    endfunction

endpackage

// File: rtl/pe_lsb.sv
// pe_lsb: priority encoder selecting the lowest set request bit
module pe_lsb #(
    parameter int W = 8
) (
    input  logic [W-1:0]         req,
    output logic [W-1:0]         ack_one_hot,
    output logic [$clog2(W)-1:0] ack_index
);
    localparam int IW = $clog2(W);

    // scan downward so the lowest set bit is the last one written
    always_comb begin
        ack_one_hot = '0;
        ack_index   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                ack_one_hot    = '0;
                ack_one_hot[i] = 1'b1;
                ack_index      = IW'(i);
            end
        end
    end
endmodule

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter with grant locking; optional watchdog via RR_LOCK_ARBITER_TIMEOUT_EN
module rr_lock_arbiter
    import arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         req_vec,
    input  logic [WIDTH-1:0]         req_last_vec,
    input  logic                     resource_ready,
    output logic                     grant_valid,
    output logic [WIDTH-1:0]         grant_one_hot,
    output logic [$clog2(WIDTH)-1:0] grant_index,
    output logic                     beat_fire,
    output logic                     timeout_pulse
);
    localparam int IW = $clog2(WIDTH);

    logic             r_grant_valid;
    logic [WIDTH-1:0] r_grant_one_hot;
    logic [IW-1:0]    r_grant_index;
    logic [IW-1:0]    r_last_index;
    logic [IW-1:0]    w_base;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_masked;
    logic [WIDTH-1:0] w_m_oh;
    logic [WIDTH-1:0] w_u_oh;
    logic [WIDTH-1:0] w_win_oh;
    logic [IW-1:0]    w_m_idx;
    logic [IW-1:0]    w_u_idx;
    logic [IW-1:0]    w_win_idx;
    logic             w_any;
    logic             w_fire;
    logic             w_norm;
    logic             w_abort;
    logic             w_force;
    logic             w_release;

    // while granted the mask is only consumed on release, when the pointer becomes grant_index
    assign w_base   = r_grant_valid ? r_grant_index : r_last_index;
    assign w_mask   = WIDTH'(above_mask(int'(w_base)));
    assign w_masked = req_vec & w_mask;

    pe_lsb #(.W(WIDTH)) u_pe_masked (
        .req         (w_masked),
        .ack_one_hot (w_m_oh),
        .ack_index   (w_m_idx)
    );

    pe_lsb #(.W(WIDTH)) u_pe_raw (
        .req         (req_vec),
        .ack_one_hot (w_u_oh),
        .ack_index   (w_u_idx)
    );

    assign w_win_oh  = |w_masked ? w_m_oh : w_u_oh;
    assign w_win_idx = |w_masked ? w_m_idx : w_u_idx;
    assign w_any     = |req_vec;

    assign w_fire    = r_grant_valid & req_vec[r_grant_index] & resource_ready;
    assign w_norm    = w_fire & req_last_vec[r_grant_index];
    assign w_abort   = r_grant_valid & ~req_vec[r_grant_index];
    assign w_release = w_norm | w_abort | w_force;

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
    localparam int CW = cnt_w(MAX_HOLD);

    logic [CW-1:0] r_hold_cnt;
    logic          r_timeout_pulse;

    assign w_force       = r_grant_valid & ~w_fire & ~w_abort & (r_hold_cnt == CW'(MAX_HOLD - 1));
    assign timeout_pulse = r_timeout_pulse;

    // stall counter restarts on every accepted beat and on each new grant
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_cnt      <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_hold_cnt      <= (!r_grant_valid | w_fire | w_release) ? '0 : r_hold_cnt + CW'(1);
            r_timeout_pulse <= w_force;
        end
    end
`else
    localparam int unused_max_hold = MAX_HOLD;

    assign w_force       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // grant is re-evaluated only when idle or releasing, so it stays locked mid-transaction
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_grant_valid   <= 1'b0;
            r_grant_one_hot <= '0;
            r_grant_index   <= '0;
            r_last_index    <= IW'(WIDTH - 1);
        end else if (!r_grant_valid | w_release) begin
            r_grant_valid   <= w_any;
            r_grant_one_hot <= w_win_oh;
            r_grant_index   <= w_win_idx;
            if (r_grant_valid)
                r_last_index <= r_grant_index;
        end
    end

    assign grant_valid   = r_grant_valid;
    assign grant_one_hot = r_grant_one_hot;
    assign grant_index   = r_grant_index;
    assign beat_fire     = w_fire;
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: table-driven directed checks of the round-robin lock arbiter
module tb_rr_lock_arbiter;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] last;
        logic       rdy;
        logic       fire;
        logic       valid;
        logic [7:0] oh;
        logic [2:0] idx;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] req_vec;
    logic [7:0] req_last_vec;
    logic       resource_ready;
    logic       grant_valid;
    logic [7:0] grant_one_hot;
    logic [2:0] grant_index;
    logic       beat_fire;
    logic       timeout_pulse;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    rr_lock_arbiter #(.WIDTH(8), .MAX_HOLD(16)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .req_vec        (req_vec),
        .req_last_vec   (req_last_vec),
        .resource_ready (resource_ready),
        .grant_valid    (grant_valid),
        .grant_one_hot  (grant_one_hot),
        .grant_index    (grant_index),
        .beat_fire      (beat_fire),
        .timeout_pulse  (timeout_pulse)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [7:0] req, input logic [7:0] last, input logic rdy,
                       input logic fire, input logic valid, input logic [7:0] oh, input logic [2:0] idx);
        vec_t v;
        v.rst = rst; v.req = req; v.last = last; v.rdy = rdy;
        v.fire = fire; v.valid = valid; v.oh = oh; v.idx = idx;
        vq.push_back(v);
    endtask

    task automatic tick_check(input string tag, input logic valid, input logic [7:0] oh,
                              input logic [2:0] idx, input logic to);
        @(posedge CLK);
        #1;
        check({tag, " valid"}, grant_valid, valid);
        check({tag, " oh"}, grant_one_hot, oh);
        check({tag, " idx"}, grant_index, idx);
        check({tag, " timeout"}, timeout_pulse, to);
    endtask

    initial begin
        RST = 1'b1; req_vec = '0; req_last_vec = '0; resource_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset valid", grant_valid, 1'b0);
        check("reset oh", grant_one_hot, 8'h00);
        check("reset idx", grant_index, 3'd0);
        check("reset timeout", timeout_pulse, 1'b0);
        check("reset fire", beat_fire, 1'b0);

        // post-reset arbitration, back-to-back handoff, abort to idle
        add(0, 8'h24, 8'h00, 0, 0, 1, 8'h04, 3'd2);
        add(0, 8'h24, 8'h00, 1, 1, 1, 8'h04, 3'd2);
        add(0, 8'h24, 8'h00, 1, 1, 1, 8'h04, 3'd2);
        add(0, 8'h24, 8'h04, 1, 1, 1, 8'h20, 3'd5);
        add(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 3'd0);
        // round-robin fairness with single-beat transactions
        add(1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 3'd0);
        add(0, 8'hFF, 8'hFF, 1, 0, 1, 8'h01, 3'd0);
        for (int k = 1; k <= 8; k++)
            add(0, 8'hFF, 8'hFF, 1, 1, 1, 8'(1 << (k % 8)), 3'(k % 8));
        // lock hold: grant 3 keeps the resource through four beats despite 0x81 waiting
        add(1, 8'hFF, 8'hFF, 1, 1, 0, 8'h00, 3'd0);
        add(0, 8'h08, 8'h00, 0, 0, 1, 8'h08, 3'd3);
        for (int k = 0; k < 7; k++)
            add(0, 8'h89, 8'h00, k[0], k[0], 1, 8'h08, 3'd3);
        add(0, 8'h89, 8'h08, 1, 1, 1, 8'h80, 3'd7);
        // reset mid-transaction, then first grant goes to the only requester 7
        add(1, 8'h80, 8'h00, 0, 0, 0, 8'h00, 3'd0);
        add(0, 8'h80, 8'h00, 0, 0, 1, 8'h80, 3'd7);
        // abort of grant 1 hands over to 4, then abort with nobody waiting goes idle
        add(1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 3'd0);
        add(0, 8'h02, 8'h00, 0, 0, 1, 8'h02, 3'd1);
        add(0, 8'h02, 8'h00, 1, 1, 1, 8'h02, 3'd1);
        add(0, 8'h10, 8'h00, 1, 0, 1, 8'h10, 3'd4);
        add(0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 3'd0);
        // releasing requester wins again when it is the only one left
        add(0, 8'h08, 8'h00, 0, 0, 1, 8'h08, 3'd3);
        add(0, 8'h08, 8'h08, 1, 1, 1, 8'h08, 3'd3);

        for (int i = 0; i < vq.size(); i++) begin
            RST = vq[i].rst; req_vec = vq[i].req; req_last_vec = vq[i].last; resource_ready = vq[i].rdy;
            #1;
            check($sformatf("v%0d fire", i), beat_fire, vq[i].fire);
            tick_check($sformatf("v%0d", i), vq[i].valid, vq[i].oh, vq[i].idx, 1'b0);
        end

        // stalled grant 4 with requester 1 waiting
        RST = 1'b1; req_vec = '0; req_last_vec = '0; resource_ready = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0; req_vec = 8'h10;
        tick_check("to grant", 1'b1, 8'h10, 3'd4, 1'b0);
        req_vec = 8'h12;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
        for (int k = 1; k <= 15; k++)
            tick_check($sformatf("to hold%0d", k), 1'b1, 8'h10, 3'd4, 1'b0);
        tick_check("to release", 1'b1, 8'h02, 3'd1, 1'b1);
        tick_check("to after", 1'b1, 8'h02, 3'd1, 1'b0);
`else
        for (int k = 1; k <= 120; k++)
            tick_check($sformatf("to hold%0d", k), 1'b1, 8'h10, 3'd4, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Round-robin arbiter with grant locking, sharing one downstream resource among WIDTH requesters. Once granted, a requester holds the resource for a multi-beat transaction until it signals its last beat. Arbitration picks the lowest-indexed request above the previous winner, using two pe_lsb instances (masked and unmasked). An optional watchdog forcibly revokes a grant that stalls too long.

## Interface
- WIDTH, 8: number of requesters; must be ≥ 2.
- MAX_HOLD, 16: cycles without an accepted beat before forced release (timeout build only); must be ≥ 2.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- req_vec  in  WIDTH  per-requester request; must stay high through its transaction.
- req_last_vec  in  WIDTH  per-requester "current beat is last"; sampled only for the granted requester.
- resource_ready  in  1  downstream accepts a beat this cycle.
- grant_valid  out  1  a grant is active (registered).
- grant_one_hot  out  WIDTH  granted requester (registered); zero when grant_valid = 0.
- grant_index  out  $clog2(WIDTH)  index of granted requester (registered).
- beat_fire  out  1  combinational: grant_valid & req_vec[grant_index] & resource_ready.
- timeout_pulse  out  1  registered one-cycle pulse on forced release.

## Operation
- State: IDLE (grant_valid = 0) and GRANTED (grant_valid = 1). The state is encoded by grant_valid.
- Priority pointer last_index: updated to grant_index whenever a grant ends.
- Masked mask: bits strictly above last_index.
- Arbitration function:
  - Compute masked = req_vec & mask and pick its LSB.
  - If masked is zero, pick the LSB of req_vec.
  - Result: winner one-hot, index, and any-request flag.
- IDLE: if req_vec ≠ 0, register the winner and enter GRANTED. Otherwise stay in IDLE.
- GRANTED, each cycle, first matching rule applies:
  - Normal release: beat_fire & req_last_vec[grant_index].
  - Abort release: req_vec[grant_index] = 0 (requester dropped without a last beat).
  - Forced release (timeout build only): hold counter reaches MAX_HOLD−1 with no fire.
  - Otherwise hold the grant. Grant outputs must not change mid-transaction.
- On any release:
  - last_index ← grant_index.
  - Re-arbitrate in the same cycle using the updated mask.
  - If any request is pending, register the new grant directly (back-to-back, no IDLE bubble). Otherwise go to IDLE.
  - The releasing requester may win again only if it is the sole requester.
- Requests from non-granted requesters never affect the current grant.

## Timing
- Reset values:
  - grant_valid = 0, grant_one_hot = 0, grant_index = 0, timeout_pulse = 0.
  - last_index = WIDTH−1, so the first grant after reset goes to the lowest requesting index.
  - hold counter = 0.
- Latency: a request seen in IDLE at cycle N gives grant_valid at N+1.
- The granted requester's first beat can fire at N+1.
- Release at cycle N (any kind) gives the new grant or IDLE at N+1.
- beat_fire is combinational from inputs and registered grant state; it has no extra latency.
- Hold counter:
  - Width $clog2(MAX_HOLD+1).
  - Clears on beat_fire, on grant start, and on release.
  - Increments on each GRANTED cycle without fire.
  - Saturating behaviour is unnecessary, because release happens at MAX_HOLD−1.
- timeout_pulse is asserted the cycle after the forced release, for exactly one cycle.
- A fire with last in the same cycle the counter hits its limit counts as a normal release; no timeout_pulse.
- RST asserted mid-transaction: all state returns to reset values on the next edge. No partial release and no pulse.

## Configuration
- RR_LOCK_ARBITER_TIMEOUT_EN defined:
  - Hold counter and forced release are present.
  - timeout_pulse behaves as above.
  - MAX_HOLD is honoured.
- Not defined:
  - No counter logic.
  - A grant is held indefinitely until a normal or abort release.
  - timeout_pulse is tied to 0 and MAX_HOLD is ignored.

## Structure
- Shared package arbiter_pkg holds the timeout-counter width helper and any reusable mask-generation functions. The mask function turns an index into "bits strictly above" it.
- Sub-module pe_lsb (existing) is instantiated twice, on masked and raw req_vec.
- Only the ack_one_hot and ack_index outputs of each pe_lsb instance are used.

## Test plan
- Post-reset arbitration (WIDTH=8): req_vec=0x24 held → grant_index=2 at cycle 1; last beat at cycle 3 → grant_index=5 at cycle 4 with no IDLE gap.
- Round-robin fairness: req_vec=0xFF constant, every beat last with ready=1 → grants cycle 0,1,…,7,0. Each index holds the grant for exactly one cycle.
- Lock hold: grant=3, other requests 0x81 asserted, 4 beats with ready toggling → grant stays at 3 until the 4th fire with last. Next grant is 7.
- Abort: grant=1 and req_vec[1] drops without last → release. Next pending requester is granted the following cycle, or grant_valid=0 if none.
- Timeout (macro defined, MAX_HOLD=16): grant=4, ready=0 for 15 cycles → release and timeout_pulse=1 for one cycle. Without the macro, the grant persists for more than 100 cycles and timeout_pulse stays 0.
- Reset mid-transaction: RST during GRANTED → next cycle all outputs are 0. With req_vec=0x80, the first grant is index 7.
